// File: rtl/button_event.sv
// rtl/button_event.sv - press/release/click/long-press/auto-repeat event generator
module button_event #(
  parameter logic [23:0] LONG_CYCLES   = 24'd12_500_000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       switch_state,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] repeat_count
);

  typedef enum logic [1:0] {
    DISARMED,
    IDLE,
    PRESSED,
    LONG
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] count;
  logic [23:0] count_nxt;
  logic [7:0]  rcount_nxt;
  logic        press_nxt;
  logic        release_nxt;
  logic        click_nxt;
  logic        long_nxt;
  logic        repeat_nxt;
  logic        held_nxt;

  // Next-state and next-output decode; release is tested first so it wins over long/repeat.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    rcount_nxt  = repeat_count;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      DISARMED: begin
        if (!switch_state) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (switch_state) begin
          state_nxt  = PRESSED;
          count_nxt  = 24'd0;
          rcount_nxt = 8'd0;
          press_nxt  = 1'b1;
        end
      end
      PRESSED: begin
        if (!switch_state) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          click_nxt   = 1'b1;
        end else if (count == LONG_CYCLES - 24'd1) begin
          state_nxt = LONG;
          count_nxt = 24'd0;
          long_nxt  = 1'b1;
        end else begin
          count_nxt = count + 24'd1;
        end
      end
      LONG: begin
        if (!switch_state) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else if (count == REPEAT_CYCLES - 24'd1) begin
          count_nxt  = 24'd0;
          repeat_nxt = 1'b1;
          if (repeat_count != 8'hFF) begin
            rcount_nxt = repeat_count + 8'd1;
          end
        end else begin
          count_nxt = count + 24'd1;
        end
      end
      default: begin
        state_nxt = DISARMED;
      end
    endcase
    held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG);
  end

  // State, counter and every output are registered together so outputs never see switch_state directly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= DISARMED;
      count         <= 24'd0;
      repeat_count  <= 8'd0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      repeat_count  <= rcount_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      click_pulse   <= click_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      held          <= held_nxt;
    end
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter: LONG_CYCLES, 24'd12_500_000, held cycles from press to long-press event; legal range 2..2^24-1.
REQ-002 Parameter: REPEAT_CYCLES, 24'd2_500_000, cycles between auto-repeat events after long-press; legal range 2..2^24-1.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset_n  input  1  synchronous, active-low reset.
REQ-005 Port: switch_state  input  1  debounced, clk-synchronous button level; 1 = pressed.
REQ-006 Port: press_pulse  output  1  one-cycle pulse on accepted press.
REQ-007 Port: release_pulse  output  1  one-cycle pulse on release of an accepted press.
REQ-008 Port: click_pulse  output  1  one-cycle pulse on release before long-press.
REQ-009 Port: long_pulse  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-010 Port: repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES after long-press while held.
REQ-011 Port: held  output  1  level; 1 while FSM is in PRESSED or LONG.
REQ-012 Port: repeat_count  output  8  number of repeat pulses in current hold, saturating.

Function
REQ-013 All outputs SHALL be registered; no combinational path from switch_state to any output.
REQ-014 FSM states SHALL be DISARMED, IDLE, PRESSED, LONG; internal hold counter 24 bits wide, unsigned.
REQ-015 DISARMED: switch_state=0 -> IDLE; switch_state=1 -> stay; no pulses.
REQ-016 IDLE: switch_state=1 sampled at edge k -> PRESSED, counter<=0, repeat_count<=0, press_pulse=1 during cycle after edge k.
REQ-017 PRESSED: switch_state=0 -> IDLE, release_pulse=1 and click_pulse=1 same cycle; else counter increments.
REQ-018 PRESSED: at edge k+LONG_CYCLES (counter==LONG_CYCLES-1 before update) with switch_state=1 -> LONG, counter<=0, long_pulse=1.
REQ-019 LONG: switch_state=0 -> IDLE, release_pulse=1, click_pulse=0; else counter increments.
REQ-020 LONG: counter==REPEAT_CYCLES-1 with switch_state=1 -> counter<=0, repeat_pulse=1, repeat_count+1 saturating at 8'd255.
REQ-021 Release SHALL take priority over long/repeat on the same edge: only release_pulse asserts.
REQ-022 Each pulse output SHALL be high exactly one cycle per event; at most one of press/long/repeat/release per cycle.
REQ-023 held SHALL be 1 in the cycle after entering PRESSED until the cycle after returning to IDLE, aligned with press_pulse/release_pulse.
REQ-024 repeat_count SHALL hold its value after release until the next accepted press clears it.
REQ-025 Counter SHALL never wrap: it is reset to 0 on every PRESSED->LONG and repeat event.

Reset
REQ-026 reset_n=0 sampled at posedge SHALL force state DISARMED, counter 0, all pulses 0, held 0, repeat_count 0.
REQ-027 Reset SHALL override all other inputs on the same edge, including mid-hold in PRESSED or LONG; no release_pulse is generated.
REQ-028 After reset, a press SHALL only be accepted after switch_state is sampled 0 at least once (reset released while held produces no press_pulse).

Verification (bench uses LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-029 Reset low 3 cycles, switch_state=0, release reset, raise switch_state at edge k=5 -> press_pulse high after edge 5, held=1; all other pulses 0.
REQ-030 Hold 3 cycles then drop -> release_pulse and click_pulse high one cycle together, held=0, long_pulse never asserted.
REQ-031 Press at edge k, hold 20 cycles -> long_pulse after k+8; repeat_pulse after k+12, k+16, k+20; repeat_count=3; release -> release_pulse, click_pulse=0.
REQ-032 Release exactly at edge k+8 -> release_pulse=1, long_pulse=0, click_pulse=1; state IDLE.
REQ-033 Reset asserted mid-LONG with switch_state=1, then released while still held -> no pulses until switch_state=0 seen, next press gives press_pulse, repeat_count=0.
REQ-034 Hold 1100 cycles in LONG -> repeat_count saturates at 255, repeat_pulse continues every 4 cycles.
